// File: rtl/otter_fetch_unit.sv
// OTTER RV32I instruction fetch stage: owns the PC, issues single-outstanding
// instruction-memory requests and presents the fetched word to decode.
module otter_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_ADDR,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] IR,
    output logic        IR_VALID,
    input  logic        IR_READY,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic        MISALIGN
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StHold,
        StDrain
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] faddr_q, faddr_d;
    logic [31:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic        misalign_q, misalign_d;

    logic [31:0] pc_inc;
    logic [31:0] target;

    assign pc_inc = pc_q + 32'd4;
    assign target = {REDIRECT_ADDR[31:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        faddr_d    = faddr_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        misalign_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                faddr_d = pc_q;
                state_d = StWait;
            end
            StWait: begin
                if (IMEM_ACK) begin
                    ir_d       = IMEM_RDATA;
                    ir_valid_d = 1'b1;
                    state_d    = StHold;
                end
            end
            StHold: begin
                if (ir_valid_q && IR_READY) begin
                    pc_d       = pc_inc;
                    faddr_d    = pc_inc;
                    ir_valid_d = 1'b0;
                    state_d    = StWait;
                end
            end
            StDrain: begin
                if (IMEM_ACK) begin
                    faddr_d = pc_q;
                    state_d = StWait;
                end
            end
            default: state_d = StIdle;
        endcase

        // Redirect wins over everything above; an in-flight request must
        // complete at its original address before the new target is issued.
        if (REDIRECT) begin
            pc_d       = target;
            ir_d       = NOP_INSTR;
            ir_valid_d = 1'b0;
            misalign_d = |REDIRECT_ADDR[1:0];
            unique case (state_q)
                StIdle, StHold: begin
                    faddr_d = target;
                    state_d = StWait;
                end
                StWait, StDrain: begin
                    if (IMEM_ACK) begin
                        faddr_d = target;
                        state_d = StWait;
                    end else begin
                        faddr_d = faddr_q;
                        state_d = StDrain;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            pc_q       <= RESET_VECTOR;
            faddr_q    <= RESET_VECTOR;
            ir_q       <= NOP_INSTR;
            ir_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            faddr_q    <= faddr_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign IMEM_REQ  = (state_q == StWait) || (state_q == StDrain);
    assign IMEM_ADDR = faddr_q;
    assign IR        = ir_q;
    assign IR_VALID  = ir_valid_q;
    assign PC        = pc_q;
    assign PC_PLUS4  = pc_inc;
    assign MISALIGN  = misalign_q;

endmodule

// File: doc/otter_fetch_unit.md
Name: otter_fetch_unit

Overview:
- Instruction fetch stage of the OTTER RV32I core.
- Owns the PC and talks to instruction memory over a single-outstanding req/ack handshake.
- Registers the fetched word into IR; IR[31:7] feeds the immediate generator and decode.
- Accepts a PC redirect from the downstream branch/jump target logic and discards any fetch already in flight.

Parameters:
- RESET_VECTOR, 32'h0000_0000: PC value after reset.
- NOP_INSTR, 32'h0000_0013: IR value after reset or redirect (addi x0,x0,0).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- REDIRECT  input  1  one-cycle request to load PC from REDIRECT_ADDR.
- REDIRECT_ADDR  input  32  target from the branch/jump/trap path.
- IMEM_REQ  output  1  fetch request; held high until IMEM_ACK.
- IMEM_ADDR  output  32  fetch address; stable while IMEM_REQ is high.
- IMEM_ACK  input  1  memory response; IMEM_RDATA valid in the same cycle.
- IMEM_RDATA  input  32  fetched instruction word.
- IR  output  32  registered instruction to decode and the immediate generator.
- IR_VALID  output  1  IR holds an unconsumed instruction.
- IR_READY  input  1  decode accepts IR; transfer occurs when IR_VALID&&IR_READY.
- PC  output  32  address of the instruction in IR (current fetch address when IR_VALID=0).
- PC_PLUS4  output  32  PC+4, combinational, for JAL/JALR link.
- MISALIGN  output  1  one-cycle pulse: REDIRECT_ADDR[1:0]!=0 was accepted.

Behaviour:
- Reset values (cycle after RST sampled high): state IDLE, PC=RESET_VECTOR, fetch-address register=RESET_VECTOR, IR=NOP_INSTR, IR_VALID=0, MISALIGN=0.
  - IMEM_REQ=0 follows from state IDLE.
  - RST overrides every other input. No drain of in-flight requests on reset; memory shares RST.
- IMEM_REQ=1 exactly in states WAIT and DRAIN. IMEM_ADDR always equals the internal fetch-address register, never the PC directly.
- State IDLE (only entered from reset):
  - Next cycle: fetch-address register <= PC, go to WAIT.
- State WAIT:
  - IMEM_ACK=1: IR<=IMEM_RDATA, IR_VALID<=1, go to HOLD.
  - IMEM_ACK=0: stay in WAIT.
- State HOLD:
  - IR_VALID&&IR_READY: PC<=PC+4, fetch-address register<=PC+4, IR_VALID<=0, go to WAIT.
  - Otherwise hold IR, PC and IR_VALID unchanged (stall).
- REDIRECT, evaluated every cycle and taking priority over the rules above:
  - PC <= {REDIRECT_ADDR[31:2],2'b00}; IR<=NOP_INSTR; IR_VALID<=0; MISALIGN<=|REDIRECT_ADDR[1:0].
  - In IDLE or HOLD: fetch-address register <= new PC, go to WAIT. An IR_READY in the same HOLD cycle still counts as a transfer of the old IR.
  - In WAIT with IMEM_ACK=1: discard IMEM_RDATA, load the fetch-address register with the new PC, go to WAIT.
  - In WAIT with IMEM_ACK=0: go to DRAIN; the fetch-address register keeps the old address (address stability rule).
- State DRAIN:
  - On IMEM_ACK: discard the data, fetch-address register<=PC, go to WAIT.
  - A further REDIRECT while in DRAIN updates PC only; stay in DRAIN.
- Latency and throughput:
  - First IR_VALID two cycles after reset release with a zero-wait memory.
  - Steady-state throughput is one instruction per 2 cycles (HOLD→WAIT→HOLD) with IR_READY held high.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- MISALIGN is low in every cycle not immediately following an accepted REDIRECT.

Test Plan:
- Reset then zero-wait memory, IR_READY=1, mem[0]=32'h00500093, mem[4]=32'h00A00113:
  - IR_VALID rises 2 cycles after reset release with IR=32'h00500093, PC=0.
  - Next valid IR=32'h00A00113, PC=4, PC_PLUS4=8.
- Stall: hold IR_READY=0 for 5 cycles in HOLD:
  - IR, PC, IR_VALID stay constant and IMEM_REQ stays 0.
  - Raising IR_READY gives IMEM_ADDR=PC+4 on the next cycle.
- Memory with 3-cycle ACK delay:
  - IMEM_REQ stays high and IMEM_ADDR stays constant for 3 cycles.
  - IR is captured only in the ACK cycle.
- REDIRECT to 32'h0000_0100 during WAIT with ACK pending 2 more cycles:
  - State DRAIN; IMEM_ADDR keeps the old address until ACK and the stale data is never presented.
  - Then IMEM_ADDR=32'h100, and the next valid IR comes from 0x100 with PC=32'h100.
- REDIRECT to 32'h0000_0202 in HOLD:
  - MISALIGN pulses for exactly one cycle, PC=32'h200, IR=NOP_INSTR, IR_VALID=0.
- Boundary cases:
  - Assert RST during DRAIN: the next cycle shows reset values with IMEM_REQ=0.
  - Redirect to 32'hFFFF_FFFC and consume one instruction: the next fetch address is 0.
